// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the MEM-stage data port (A)
// and a secondary master (B). One multi-cycle SRAM transaction is sequenced at
// a time. The winner gets a one-cycle ready pulse and held read data. A
// watchdog aborts transactions whose controller never answers.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (alternating tie-break).
// Without it, ties go to port A (fixed priority).
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_wrEn,
  input  logic              a_rdEn,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_writeData,
  output logic [DATA_W-1:0] a_readData,
  output logic              a_ready,
  input  logic              b_wrEn,
  input  logic              b_rdEn,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_writeData,
  output logic [DATA_W-1:0] b_readData,
  output logic              b_ready,
  output logic              mem_wrEn,
  output logic              mem_rdEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_A,
    BUSY_B,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wd_count;
  logic             a_req;
  logic             b_req;
  logic             grant_b;
  logic             expired;
  logic             finish;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // 1 = port A won the last grant; reset value 0 means "B last" so A wins the first tie
  logic last_a;
`endif

  // Request decode, arbitration and transaction-finish detection
  always_comb begin
    a_req = a_wrEn | a_rdEn;
    b_req = b_wrEn | b_rdEn;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    grant_b = b_req & (~a_req | last_a);
`else
    grant_b = b_req & ~a_req;
`endif
    // The counter holds the number of busy cycles already spent, so the
    // TIMEOUT-th strobe cycle is the last one before the watchdog fires.
    expired = (wd_count == CNT_W'(TIMEOUT - 1));
    finish  = mem_ready | expired;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a finishing port can drop its request
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (a_req | b_req) begin
          state_next = grant_b ? BUSY_B : BUSY_A;
        end
      end
      BUSY_A, BUSY_B: begin
        if (finish) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the granted request, complete it, pulse ready and run the watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wrEn      <= 1'b0;
      mem_rdEn      <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
      a_readData    <= '0;
      b_readData    <= '0;
      a_ready       <= 1'b0;
      b_ready       <= 1'b0;
      timeout_err   <= 1'b0;
      wd_count      <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_a        <= 1'b0;
`endif
    end else begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            wd_count <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_a   <= ~grant_b;
`endif
            // A request with both enables set is a write
            if (grant_b) begin
              mem_wrEn      <= b_wrEn;
              mem_rdEn      <= b_rdEn & ~b_wrEn;
              mem_address   <= b_address;
              mem_writeData <= b_writeData;
            end else begin
              mem_wrEn      <= a_wrEn;
              mem_rdEn      <= a_rdEn & ~a_wrEn;
              mem_address   <= a_address;
              mem_writeData <= a_writeData;
            end
          end
        end
        BUSY_A, BUSY_B: begin
          if (finish) begin
            mem_wrEn <= 1'b0;
            mem_rdEn <= 1'b0;
            if (state == BUSY_A) begin
              a_ready <= 1'b1;
            end else begin
              b_ready <= 1'b1;
            end
            if (!mem_ready) begin
              // Watchdog abort: the owner's read data is zeroed whatever the op was
              timeout_err <= 1'b1;
              if (state == BUSY_A) begin
                a_readData <= '0;
              end else begin
                b_readData <= '0;
              end
            end else if (mem_rdEn) begin
              if (state == BUSY_A) begin
                a_readData <= mem_readData;
              end else begin
                b_readData <= mem_readData;
              end
            end
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end
        DONE: begin
          wd_count <= '0;
        end
        default: begin
          wd_count <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a transaction-level model predicts
// every output each cycle, directed scenarios pin key values with literals,
// then a randomized phase exercises both requesters against random SRAM timing.
module tb_sram_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              a_wrEn = 1'b0;
  logic              a_rdEn = 1'b0;
  logic [ADDR_W-1:0] a_address = '0;
  logic [DATA_W-1:0] a_writeData = '0;
  logic [DATA_W-1:0] a_readData;
  logic              a_ready;
  logic              b_wrEn = 1'b0;
  logic              b_rdEn = 1'b0;
  logic [ADDR_W-1:0] b_address = '0;
  logic [DATA_W-1:0] b_writeData = '0;
  logic [DATA_W-1:0] b_readData;
  logic              b_ready;
  logic              mem_wrEn;
  logic              mem_rdEn;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writeData;
  logic [DATA_W-1:0] mem_readData = '0;
  logic              mem_ready = 1'b0;
  logic              busy;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  sram_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .a_wrEn       (a_wrEn),
    .a_rdEn       (a_rdEn),
    .a_address    (a_address),
    .a_writeData  (a_writeData),
    .a_readData   (a_readData),
    .a_ready      (a_ready),
    .b_wrEn       (b_wrEn),
    .b_rdEn       (b_rdEn),
    .b_address    (b_address),
    .b_writeData  (b_writeData),
    .b_readData   (b_readData),
    .b_ready      (b_ready),
    .mem_wrEn     (mem_wrEn),
    .mem_rdEn     (mem_rdEn),
    .mem_address  (mem_address),
    .mem_writeData(mem_writeData),
    .mem_readData (mem_readData),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Tracks who owns the SRAM, how many busy cycles it has spent, and whether
  // we are in the one-cycle settle gap after a completion.
  int                m_owner;     // 0 none, 1 port A, 2 port B
  int                m_age;
  bit                m_settle;
  bit                m_wr;
  bit                m_a_last;
  bit                m_pick_b;
  logic              exp_mem_wrEn, exp_mem_rdEn, exp_a_ready, exp_b_ready;
  logic              exp_timeout_err, exp_busy;
  logic [ADDR_W-1:0] exp_mem_address;
  logic [DATA_W-1:0] exp_mem_writeData, exp_a_readData, exp_b_readData;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_age = 0; m_settle = 0; m_wr = 0; m_a_last = 0;
      exp_mem_wrEn = 0; exp_mem_rdEn = 0; exp_a_ready = 0; exp_b_ready = 0;
      exp_timeout_err = 0; exp_busy = 0;
      exp_mem_address = '0; exp_mem_writeData = '0;
      exp_a_readData = '0; exp_b_readData = '0;
    end else begin
      exp_a_ready = 0;
      exp_b_ready = 0;
      if (m_settle) begin
        m_settle = 0;
      end else if (m_owner != 0) begin
        m_age++;
        if (mem_ready || m_age == TIMEOUT) begin
          exp_mem_wrEn = 0;
          exp_mem_rdEn = 0;
          if (m_owner == 1) begin
            exp_a_ready = 1;
            if (!mem_ready) exp_a_readData = '0;
            else if (!m_wr) exp_a_readData = mem_readData;
          end else begin
            exp_b_ready = 1;
            if (!mem_ready) exp_b_readData = '0;
            else if (!m_wr) exp_b_readData = mem_readData;
          end
          if (!mem_ready) exp_timeout_err = 1;
          m_owner  = 0;
          m_settle = 1;
        end
      end else if (a_wrEn || a_rdEn || b_wrEn || b_rdEn) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        m_pick_b = (b_wrEn || b_rdEn) && (!(a_wrEn || a_rdEn) || m_a_last);
`else
        m_pick_b = !(a_wrEn || a_rdEn);
`endif
        m_owner           = m_pick_b ? 2 : 1;
        m_a_last          = !m_pick_b;
        m_age             = 0;
        m_wr              = m_pick_b ? b_wrEn : a_wrEn;
        exp_mem_wrEn      = m_wr;
        exp_mem_rdEn      = !m_wr;
        exp_mem_address   = m_pick_b ? b_address : a_address;
        exp_mem_writeData = m_pick_b ? b_writeData : a_writeData;
      end
      exp_busy = (m_owner != 0) || m_settle;
    end
  end

  // Compare every DUT output against the model once per cycle, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("mem_wrEn", mem_wrEn, exp_mem_wrEn);
      checkOutput("mem_rdEn", mem_rdEn, exp_mem_rdEn);
      checkOutput("mem_address", mem_address, exp_mem_address);
      checkOutput("mem_writeData", mem_writeData, exp_mem_writeData);
      checkOutput("a_ready", a_ready, exp_a_ready);
      checkOutput("b_ready", b_ready, exp_b_ready);
      checkOutput("a_readData", a_readData, exp_a_readData);
      checkOutput("b_readData", b_readData, exp_b_readData);
      checkOutput("busy", busy, exp_busy);
      checkOutput("timeout_err", timeout_err, exp_timeout_err);
    end
  end

  // Bounded wait for a ready pulse; an expired budget shows up as a failed check
  task automatic waitReady(input bit port_b, input int budget);
    int n = 0;
    while (((port_b ? b_ready : a_ready) !== 1'b1) && n < budget) begin
      tick();
      n++;
    end
    if (port_b) checkOutput("b_ready_wait", b_ready, 1);
    else        checkOutput("a_ready_wait", a_ready, 1);
  endtask

  // Random requesters honouring the hold-until-after-ready contract, random SRAM latency
  task automatic applyStimulus(input int cycles);
    bit         a_pend = 0;
    bit         b_pend = 0;
    logic [1:0] op;
    for (int i = 0; i < cycles; i++) begin
      tick();
      mem_ready    = ($urandom_range(0, 2) == 0);
      mem_readData = $urandom();
      if (a_ready) begin
        a_pend = 0;
      end else if (!a_pend) begin
        if ($urandom_range(0, 1) == 1) begin
          op = 2'($urandom_range(1, 3));
          a_wrEn = op[1]; a_rdEn = op[0];
          a_address = $urandom(); a_writeData = $urandom();
          a_pend = 1;
        end else begin
          a_wrEn = 0; a_rdEn = 0;
        end
      end
      if (b_ready) begin
        b_pend = 0;
      end else if (!b_pend) begin
        if ($urandom_range(0, 1) == 1) begin
          op = 2'($urandom_range(1, 3));
          b_wrEn = op[1]; b_rdEn = op[0];
          b_address = $urandom(); b_writeData = $urandom();
          b_pend = 1;
        end else begin
          b_wrEn = 0; b_rdEn = 0;
        end
      end
    end
  endtask

  initial begin : main
    logic [5:0] order;
    int         count;
    int         strobes;
    int         n;

    // Reset state
    rst = 0;
    repeat (3) tick();
    check_en = 1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_mem_rdEn", mem_rdEn, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);
    checkOutput("reset_a_readData", a_readData, 0);
    rst = 1;
    repeat (2) tick();

    // 1: port A read, SRAM answers 4 cycles after the strobe
    $display("[TB] scenario 1: port A read");
    a_rdEn = 1; a_address = 32'h0000_0010;
    checkOutput("s1_no_strobe_yet", mem_rdEn, 0);
    tick();
    checkOutput("s1_mem_rdEn", mem_rdEn, 1);
    checkOutput("s1_mem_address", mem_address, 32'h10);
    repeat (4) tick();
    mem_ready = 1; mem_readData = 32'h1234_5678;
    tick();
    mem_ready = 0;
    checkOutput("s1_a_ready", a_ready, 1);
    checkOutput("s1_a_readData", a_readData, 32'h1234_5678);
    checkOutput("s1_b_ready", b_ready, 0);
    tick();
    a_rdEn = 0;
    checkOutput("s1_a_ready_one_cycle", a_ready, 0);
    checkOutput("s1_busy_dropped", busy, 0);
    tick();

    // 2: simultaneous A write and B read; A wins, B follows after DONE
    $display("[TB] scenario 2: A write and B read together");
    a_wrEn = 1; a_address = 32'h20; a_writeData = 32'hDEAD_BEEF;
    b_rdEn = 1; b_address = 32'h30;
    tick();
    checkOutput("s2_mem_wrEn", mem_wrEn, 1);
    checkOutput("s2_mem_address", mem_address, 32'h20);
    checkOutput("s2_mem_writeData", mem_writeData, 32'hDEAD_BEEF);
    mem_ready = 1; mem_readData = 32'h1111_1111;
    tick();
    mem_ready = 0;
    checkOutput("s2_a_ready", a_ready, 1);
    checkOutput("s2_b_waits", b_ready, 0);
    tick();
    a_wrEn = 0;
    checkOutput("s2_idle_gap", mem_rdEn, 0);
    tick();
    checkOutput("s2_b_granted", mem_rdEn, 1);
    checkOutput("s2_b_address", mem_address, 32'h30);
    mem_ready = 1; mem_readData = 32'hA5A5_0002;
    tick();
    mem_ready = 0;
    checkOutput("s2_b_ready", b_ready, 1);
    checkOutput("s2_b_readData", b_readData, 32'hA5A5_0002);
    tick();
    b_rdEn = 0;
    tick();

    // 3: continuous traffic from both ports, six grants
    $display("[TB] scenario 3: continuous A and B traffic");
    a_rdEn = 1; a_address = 32'h100;
    b_rdEn = 1; b_address = 32'h200;
    mem_ready = 1; mem_readData = 32'h33;
    order = '0; count = 0; n = 0;
    while (count < 6 && n < 80) begin
      tick();
      n++;
      if (a_ready) begin order[count] = 1'b0; count++; end
      else if (b_ready) begin order[count] = 1'b1; count++; end
    end
    tick();
    a_rdEn = 0; b_rdEn = 0; mem_ready = 0;
    repeat (2) tick();
    checkOutput("s3_grant_count", count, 6);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    checkOutput("s3_grant_order", order, 6'b101010);
`else
    checkOutput("s3_grant_order", order, 6'b000000);
`endif

    // 4: watchdog on a B write that never sees mem_ready
    $display("[TB] scenario 4: watchdog timeout");
    b_wrEn = 1; b_address = 32'h40; b_writeData = 32'h55AA;
    strobes = 0; n = 0;
    do begin
      tick();
      n++;
      if (mem_wrEn) strobes++;
    end while (!b_ready && n < 300);
    checkOutput("s4_b_ready", b_ready, 1);
    checkOutput("s4_strobe_cycles", strobes, 255);
    checkOutput("s4_strobe_cleared", mem_wrEn, 0);
    checkOutput("s4_timeout_err", timeout_err, 1);
    checkOutput("s4_b_readData_zeroed", b_readData, 0);
    tick();
    b_wrEn = 0;
    tick();
    a_rdEn = 1; a_address = 32'h44;
    mem_ready = 1; mem_readData = 32'h0BAD_F00D;
    waitReady(1'b0, 10);
    checkOutput("s4_good_read", a_readData, 32'h0BAD_F00D);
    checkOutput("s4_err_sticky", timeout_err, 1);
    mem_ready = 0;
    tick();
    a_rdEn = 0;
    tick();

    // 5: asynchronous reset in the middle of an A transaction
    $display("[TB] scenario 5: reset while busy");
    a_rdEn = 1; a_address = 32'h50;
    repeat (2) tick();
    #2;
    rst = 0;
    #1;
    checkOutput("s5_async_mem_rdEn", mem_rdEn, 0);
    checkOutput("s5_async_busy", busy, 0);
    checkOutput("s5_async_timeout_err", timeout_err, 0);
    checkOutput("s5_async_a_readData", a_readData, 0);
    a_rdEn = 0;
    tick();
    checkOutput("s5_no_a_ready", a_ready, 0);
    rst = 1;
    tick();
    checkOutput("s5_still_no_a_ready", a_ready, 0);
    a_rdEn = 1; a_address = 32'h60;
    mem_ready = 1; mem_readData = 32'h600D_600D;
    waitReady(1'b0, 10);
    checkOutput("s5_fresh_read", a_readData, 32'h600D_600D);
    mem_ready = 0;
    tick();
    a_rdEn = 0;
    tick();

    // 6: B read then B write; write leaves b_readData alone
    $display("[TB] scenario 6: B read then B write");
    b_rdEn = 1; b_address = 32'h70;
    mem_ready = 1; mem_readData = 32'hCAFE_0001;
    waitReady(1'b1, 10);
    checkOutput("s6_b_readData", b_readData, 32'hCAFE_0001);
    mem_ready = 0;
    tick();
    b_rdEn = 0;
    tick();
    checkOutput("s6_no_regrant", busy, 0);
    b_wrEn = 1; b_writeData = 32'h55;
    mem_ready = 1; mem_readData = 32'hFFFF_FFFF;
    waitReady(1'b1, 10);
    checkOutput("s6_b_readData_held", b_readData, 32'hCAFE_0001);
    mem_ready = 0;
    tick();
    b_wrEn = 0;
    tick();

    // Randomized traffic checked cycle by cycle against the model
    $display("[TB] random phase");
    applyStimulus(3000);
    a_wrEn = 0; a_rdEn = 0; b_wrEn = 0; b_rdEn = 0; mem_ready = 1;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
